// File: rtl/quad_up_down_decoder.sv
// Quadrature decoder: synchronises A/B phases, decodes Gray steps into a loadable wrap-around position count.
// Latency: phase change before edge N shows in count/step/dir/err after edge N+2; decode idle for 4 edges after reset.
// Backpressure: none; the encoder is free-running, and changes faster than one per 2 clk cycles may alias into err.
module quad_up_down_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             dir,
    output logic             err
);

    logic       sa1, sa2, sb1, sb2;
    logic [1:0] prev;
    logic [1:0] cur;
    logic [1:0] wu;
    logic       active;
    logic       up_ev;
    logic       dn_ev;
    logic       bad_ev;
    logic [1:0] delta;

    // Rank {a,b} along the up sequence 00->10->11->01, so a step is +/-1 modulo 4.
    function automatic logic [1:0] phase_pos(input logic [1:0] ab);
        logic [1:0] p;
        case (ab)
            2'b00:   p = 2'd0;
            2'b10:   p = 2'd1;
            2'b11:   p = 2'd2;
            default: p = 2'd3;
        endcase
        return p;
    endfunction

    assign cur = {sa2, sb2};

    // Classify the transition prev->cur; a distance of 2 means both phases flipped.
    always_comb begin
        active = (wu == 2'd3);
        delta  = phase_pos(cur) - phase_pos(prev);
        up_ev  = 1'b0;
        dn_ev  = 1'b0;
        bad_ev = 1'b0;
        if (active) begin
            case (delta)
                2'd1:    up_ev  = 1'b1;
                2'd3:    dn_ev  = 1'b1;
                2'd2:    bad_ev = 1'b1;
                default: ;
            endcase
        end
    end

    // Synchronizer, warm-up counter, decode history and registered outputs; load overrides the step on count only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sa1   <= 1'b0;
            sa2   <= 1'b0;
            sb1   <= 1'b0;
            sb2   <= 1'b0;
            prev  <= 2'b00;
            wu    <= 2'd0;
            count <= '0;
            step  <= 1'b0;
            dir   <= 1'b0;
            err   <= 1'b0;
        end else begin
            sa1  <= a_in;
            sa2  <= sa1;
            sb1  <= b_in;
            sb2  <= sb1;
            prev <= cur;
            if (!active) begin
                wu <= wu + 2'd1;
            end
            step <= up_ev | dn_ev;
            err  <= bad_ev;
            if (up_ev) begin
                dir <= 1'b1;
            end else if (dn_ev) begin
                dir <= 1'b0;
            end
            if (load) begin
                count <= data;
            end else if (up_ev) begin
                count <= count + WIDTH'(1);
            end else if (dn_ev) begin
                count <= count - WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/quad_up_down_decoder.md
# quad_up_down_decoder

Quadrature decoder feeding an 8-bit loadable position counter. It takes two phase inputs from an incremental encoder and synchronises them. It decodes each Gray-code transition into an up or down step, or flags an illegal double-bit change. It maintains a wrap-around position count that can be preset from `data`.

## Interface
- `WIDTH`, default 8: position counter and `data` width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `a_in`  in  1  encoder phase A; asynchronous to `clk`.
- `b_in`  in  1  encoder phase B; asynchronous to `clk`.
- `load`  in  1  synchronous preset strobe.
- `data`  in  WIDTH  preset value.
- `count`  out  WIDTH  current position.
- `step`  out  1  one-cycle pulse per legal transition decoded.
- `dir`  out  1  direction of last legal step: 1 = up, 0 = down.
- `err`  out  1  one-cycle pulse on an illegal transition (both phases changed).

## Operation
- Synchronizer: two flops per phase, `sa1→sa2` and `sb1→sb2`. The decoder uses only `{sa2,sb2}`.
- `prev[1:0]` holds the last decoded phase pair; `cur = {sa2,sb2}`.
- Up sequence (A leads B), with `{a,b}` = 00→10→11→01→00.
- Down sequence: the exact reverse, 00→01→11→10→00.
- Each cycle outside warm-up:
  - `cur == prev`: no event.
  - One-bit change in the up direction: `step=1`, `dir=1`, `count+1`.
  - One-bit change in the down direction: `step=1`, `dir=0`, `count-1`.
  - Two-bit change (00↔11, 10↔01): `err=1`, `step=0`, `count` and `dir` unchanged.
  - `prev <= cur` in every case, including error.
- Warm-up: a 2-bit counter `wu` is cleared by reset and saturates at 3.
  - While `wu < 3`: `prev <= cur`, with no step, err or count change from decode.
  - This prevents a false event from the reset state of the synchronizer.
- Load:
  - `load=1` sets `count <= data` on the next edge and overrides any decoded step that cycle.
  - `step`, `dir` and `err` still report the decode result.
  - Load is honoured during warm-up.
- Arithmetic: modulo 2^WIDTH.
  - 8'hFF + up → 8'h00.
  - 8'h00 + down → 8'hFF.
  - No saturation and no overflow flag.
- Reset (`rst=0` at an edge):
  - `count=0`, `step=0`, `dir=0`, `err=0`.
  - `sa1`, `sa2`, `sb1`, `sb2`, `prev` and `wu` all cleared.
  - Reset has priority over `load` and decode.
  - Asserting reset mid-sequence discards all in-flight synchronizer state.

## Timing
- All outputs are registered.
- `step`, `dir` and `err` are valid in the same cycle in which `count` reflects the step.
- Latency: a phase change set up before edge N is captured in `s*1` at N and in `s*2` at N+1. It is decoded and `count`/`step` update at edge N+2.
  - `count` shows the new value after edge N+2.
  - `step` is high for exactly the cycle between edges N+2 and N+3.
- Maximum legal input rate: one phase change per 2 `clk` cycles. Faster input can alias into an `err`, which is the intended indication.
- After `rst` deasserts at edge R: decode is first active at edge R+4, when `wu` reaches 3. Load is usable from edge R+1.
- `step` and `err` are never high in the same cycle.

## Test plan
- Reset with phases at 11, release, hold phases → after warm-up: `count=0`, no `step`, no `err` at any cycle.
- Drive 8 up transitions (00→10→11→01→00 twice), 4 cycles apart → `count=8`, `dir=1`.
  - 8 single-cycle `step` pulses.
  - Each pulse occurs 3 edges after its input change.
- Load `data=8'h01`, then 2 down transitions → `count=8'hFF`, `dir=0`.
- Load `data=8'hFF`, then 1 up transition → `count=8'h00` (wrap).
- From 00, jump both phases to 11 → `err` pulses one cycle, `count` and `dir` unchanged. A following 11→01 counts up normally.
- Load asserted on the same edge as a decoded up step, with `data=8'h40` → `count=8'h40` (not 8'h41), `step=1`, `dir=1`.
- Reset asserted mid-sequence → all outputs 0 on the next edge, and warm-up restarts.
